// File: rtl/seg_reader_pkg.sv
// Shared constants and helpers for the seven-segment display reader.
// Holds the active-low segment patterns, the BCD width and the anode encodings.
package seg_pkg;

    localparam int BCD_W = 4;

    localparam logic [3:0] ALL_ON  = 4'b0000;
    localparam logic [3:0] ALL_OFF = 4'b1111;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;

    // All anodes low drives every digit; a single low anode selects that digit.
    function automatic logic [3:0] anode_targets(input logic [3:0] an);
        logic [3:0] low;
        logic [3:0] mask;
        low = ~an;
        mask = 4'b0000;
        if (an == ALL_ON)
            mask = 4'b1111;
        else if ((low != 4'b0000) && ((low & (low - 4'd1)) == 4'b0000))
            mask = low;
        return mask;
    endfunction

endpackage

// File: rtl/seg_reader_if.sv
// Bundle of sampled display inputs and captured digit outputs.
// The master drives the display lines; the reader is the slave.
interface seg_reader_if;
    logic [3:0]  an_in;
    logic [6:0]  seg_in;
    logic        dp_in;
    logic [15:0] digits;
    logic [3:0]  valid;
    logic [3:0]  err;
    logic        upd;

    modport master (
        output an_in, seg_in, dp_in,
        input  digits, valid, err, upd
    );

    modport slave (
        input  an_in, seg_in, dp_in,
        output digits, valid, err, upd
    );
endinterface

// File: rtl/seg_pat_dec.sv
// Combinational decoder from an active-low gfedcba pattern to a BCD value.
// o_ok is low for any pattern that is not one of the ten digit shapes.
module seg_pat_dec
    import seg_pkg::*;
(
    input  logic [6:0]       i_pat,
    output logic [BCD_W-1:0] o_val,
    output logic             o_ok
);

    always_comb begin
        o_val = '0;
        o_ok  = 1'b1;
        case (i_pat)
            SEG_0:   o_val = 4'd0;
            SEG_1:   o_val = 4'd1;
            SEG_2:   o_val = 4'd2;
            SEG_3:   o_val = 4'd3;
            SEG_4:   o_val = 4'd4;
            SEG_5:   o_val = 4'd5;
            SEG_6:   o_val = 4'd6;
            SEG_7:   o_val = 4'd7;
            SEG_8:   o_val = 4'd8;
            SEG_9:   o_val = 4'd9;
            default: o_ok  = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_reader.sv
// Reads a multiplexed four-digit seven-segment display back into BCD digits,
// capturing each pattern once it has been stable and ageing out stale digits.
module seg_reader
    import seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int TIMEOUT       = 1000000
)(
    input  logic         clk,
    input  logic         rst_n,
    seg_reader_if.slave  bus
);

    localparam int SCW = $clog2(STABLE_CYCLES + 1);
    localparam int TCW = $clog2(TIMEOUT + 1);
    localparam logic [SCW-1:0] STABLE_MAX  = SCW'(STABLE_CYCLES);
    localparam logic [SCW-1:0] STABLE_PRE  = SCW'(STABLE_CYCLES - 1);
    localparam logic [TCW-1:0] TIMEOUT_PRE = TCW'(TIMEOUT - 1);
    localparam logic [10:0]    IDLE_ANSEG  = {ALL_OFF, 7'h7F};
    localparam logic [11:0]    SYNC_IDLE   = {1'b1, IDLE_ANSEG};

    logic [11:0]               r_sync1;
    logic [11:0]               r_sync2;
    logic [10:0]               r_prev;
    logic [SCW-1:0]            r_stab;
    logic [15:0]               r_digits;
    logic [3:0]                r_valid;
    logic [3:0]                r_err;
    logic                      r_upd;
    logic [3:0][TCW-1:0]       r_tcnt;

    logic [10:0]               w_cur;
    logic                      w_same;
    logic [SCW-1:0]            w_stab_next;
    logic                      w_capture;
    logic [3:0]                w_mask;
    logic [BCD_W-1:0]          w_dec_val;
    logic                      w_dec_ok;
    logic [15:0]               w_digits_next;
    logic                      w_unused_dp;

    assign w_cur       = r_sync2[10:0];
    assign w_unused_dp = r_sync2[11];
    assign w_same      = (w_cur == r_prev);
    assign w_capture   = w_same && (r_stab == STABLE_PRE);
    assign w_mask      = w_capture ? anode_targets(w_cur[10:7]) : 4'b0000;

    always_comb begin
        w_stab_next = '0;
        if (w_same)
            w_stab_next = (r_stab == STABLE_MAX) ? r_stab : r_stab + 1'b1;
    end

    seg_pat_dec u_dec (
        .i_pat (w_cur[6:0]),
        .o_val (w_dec_val),
        .o_ok  (w_dec_ok)
    );

    always_comb begin
        w_digits_next = r_digits;
        for (int i = 0; i < 4; i++)
            if (w_mask[i] && w_dec_ok)
                w_digits_next[4*i +: 4] = w_dec_val;
    end

    // Two-flop synchronizer idles at all-ones so reset looks like a blank display.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= SYNC_IDLE;
            r_sync2 <= SYNC_IDLE;
            r_prev  <= IDLE_ANSEG;
            r_stab  <= '0;
        end else begin
            r_sync1 <= {bus.dp_in, bus.an_in, bus.seg_in};
            r_sync2 <= r_sync1;
            r_prev  <= w_cur;
            r_stab  <= w_stab_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digits <= '0;
            r_valid  <= '0;
            r_err    <= '0;
            r_upd    <= 1'b0;
            r_tcnt   <= '0;
        end else begin
            r_digits <= w_digits_next;
            r_upd    <= (w_digits_next != r_digits);
            for (int i = 0; i < 4; i++) begin
                if (w_mask[i])
                    r_err[i] <= !w_dec_ok;
                // A good capture beats a timeout landing on the same cycle.
                if (w_mask[i] && w_dec_ok) begin
                    r_valid[i] <= 1'b1;
                    r_tcnt[i]  <= '0;
                end else if (r_valid[i]) begin
                    r_tcnt[i] <= r_tcnt[i] + 1'b1;
                    if (r_tcnt[i] == TIMEOUT_PRE)
                        r_valid[i] <= 1'b0;
                end
            end
        end
    end

    assign bus.digits = r_digits;
    assign bus.valid  = r_valid;
    assign bus.err    = r_err;
    assign bus.upd    = r_upd;

endmodule
